// File: rtl/uart_codec_pkg.sv
// Shared types and helpers for the word<->UART-byte codec.
// Holds the TX state encoding and the bytes-per-word calculation.
package uart_codec_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SEND,
      TX_WAIT_BUSY,
      TX_WAIT_DONE
   } tx_state_t;

   function automatic int bytes_per_word(input int word_size,
                                         input int uart_width);
      return (word_size + uart_width - 1) / uart_width;
   endfunction

endpackage

// File: rtl/uart_word_codec_rx.sv
// word_rx_assembler: collects UART bytes into a word, drops stale partials.
// Ports: clk, rstN, byteValid/byteIn in; dataOut, done, timeout out.
module word_rx_assembler
   import uart_codec_pkg::*;
#(
   parameter int WORD_SIZE      = 24,
   parameter int UART_WIDTH     = 8,
   parameter int MSB_FIRST      = 1,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  byteValid,
   input  logic [UART_WIDTH-1:0] byteIn,
   output logic [WORD_SIZE-1:0]  dataOut,
   output logic                  done,
   output logic                  timeout
);

   localparam int BYTE_COUNT = bytes_per_word(WORD_SIZE, UART_WIDTH);
   localparam int PAD_W = BYTE_COUNT * UART_WIDTH;
   localparam int IDX_W = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_COUNT - 1);
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST =
      TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [PAD_W-1:0] asmWord;
   logic [PAD_W-1:0] merged;
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] slot;
   logic [TMR_W-1:0] tmr;

   // The n-th received byte lands in the slot matching the byte order.
   always_comb begin
      slot   = (MSB_FIRST != 0) ? LAST_IDX - cnt : cnt;
      merged = asmWord
             & ~(PAD_W'({UART_WIDTH{1'b1}}) << (int'(slot) * UART_WIDTH))
             | (PAD_W'(byteIn) << (int'(slot) * UART_WIDTH));
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         asmWord <= '0;
         cnt     <= '0;
         tmr     <= '0;
         dataOut <= '0;
         done    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         if (byteValid) begin
            // A byte always beats an expiring timer.
            tmr <= '0;
            if (cnt == LAST_IDX) begin
               cnt     <= '0;
               dataOut <= merged[WORD_SIZE-1:0];
               done    <= 1'b1;
            end else begin
               cnt     <= cnt + 1'b1;
               asmWord <= merged;
            end
         end else if (TIMEOUT_CYCLES != 0 && cnt != '0) begin
            if (tmr == TMR_LAST) begin
               cnt     <= '0;
               tmr     <= '0;
               timeout <= 1'b1;
            end else begin
               tmr <= tmr + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_word_codec.sv
// uart_word_codec: splits memory words into UART bytes and reassembles RX.
// Ports: txStart/dataFromMem/txReady, txByte* handshake, RX byte in, word out.
module uart_word_codec
   import uart_codec_pkg::*;
#(
   parameter int WORD_SIZE      = 24,
   parameter int UART_WIDTH     = 8,
   parameter int MSB_FIRST      = 1,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  txStart,
   input  logic [WORD_SIZE-1:0]  dataFromMem,
   output logic                  txReady,
   input  logic                  txByteReady,
   output logic                  txByteStart,
   output logic [UART_WIDTH-1:0] byteForTx,
   input  logic                  rx_new_byte_indicate,
   input  logic [UART_WIDTH-1:0] byteFromRx,
   output logic [WORD_SIZE-1:0]  dataToMem,
   output logic                  rxDone,
   output logic                  rxTimeout
);

   localparam int BYTE_COUNT = bytes_per_word(WORD_SIZE, UART_WIDTH);
   localparam int PAD_W = BYTE_COUNT * UART_WIDTH;
   localparam int IDX_W = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_COUNT - 1);

   tx_state_t        txState;
   tx_state_t        txNext;
   logic [PAD_W-1:0] txWord;
   logic [IDX_W-1:0] txIdx;
   logic [IDX_W-1:0] txSlot;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         txState <= TX_IDLE;
         txWord  <= '0;
         txIdx   <= '0;
      end else begin
         txState <= txNext;
         if (txState == TX_IDLE && txStart) begin
            // Zero extension puts the pad bits at the top of the MS byte.
            txWord <= PAD_W'(dataFromMem);
            txIdx  <= '0;
         end else if (txState == TX_WAIT_DONE && txByteReady
                      && txIdx != LAST_IDX) begin
            txIdx <= txIdx + 1'b1;
         end
      end
   end

   always_comb begin
      txNext      = txState;
      txReady     = 1'b0;
      txByteStart = 1'b0;
      unique case (txState)
         TX_IDLE: begin
            txReady = 1'b1;
            if (txStart) txNext = TX_SEND;
         end
         TX_SEND: begin
            if (txByteReady) begin
               txByteStart = 1'b1;
               txNext      = TX_WAIT_BUSY;
            end
         end
         TX_WAIT_BUSY: begin
            if (!txByteReady) txNext = TX_WAIT_DONE;
         end
         TX_WAIT_DONE: begin
            if (txByteReady)
               txNext = (txIdx == LAST_IDX) ? TX_IDLE : TX_SEND;
         end
         default: txNext = TX_IDLE;
      endcase
   end

   always_comb begin
      txSlot    = (MSB_FIRST != 0) ? LAST_IDX - txIdx : txIdx;
      byteForTx = UART_WIDTH'(txWord >> (int'(txSlot) * UART_WIDTH));
   end

   word_rx_assembler #(
      .WORD_SIZE      (WORD_SIZE),
      .UART_WIDTH     (UART_WIDTH),
      .MSB_FIRST      (MSB_FIRST),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) uRx (
      .clk       (clk),
      .rstN      (rstN),
      .byteValid (rx_new_byte_indicate),
      .byteIn    (byteFromRx),
      .dataOut   (dataToMem),
      .done      (rxDone),
      .timeout   (rxTimeout)
   );

endmodule

// File: tb/tb_uart_word_codec.sv
// Directed bench for uart_word_codec: three parameter sets share one
// byte-level UART model; A also loops TX back into its own RX.
`timescale 1ns/1ps
module tb_uart_word_codec;

   localparam int BUSY = 8;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic loop = 1'b0;
   always #10 clk = ~clk;

   int nVec = 0;
   int nMis = 0;

   // DUT A: 24-bit, MSB first, short timeout
   logic        txStartA = 1'b0;
   logic [23:0] dataA = '0;
   logic        txReadyA, txByteStartA;
   logic [7:0]  byteForTxA;
   logic        rxNewA, rxNewDrvA = 1'b0;
   logic [7:0]  byteFromRxA, byteDrvA = '0;
   logic [23:0] dataToMemA;
   logic        rxDoneA, rxTimeoutA;

   // DUT B: 24-bit, LSB first
   logic        txStartB = 1'b0;
   logic [23:0] dataB = '0;
   logic        txReadyB, txByteStartB;
   logic [7:0]  byteForTxB;
   logic        rxNewB = 1'b0;
   logic [7:0]  byteB = '0;
   logic [23:0] dataToMemB;
   logic        rxDoneB, rxTimeoutB;

   // DUT C: 20-bit, MSB first
   logic        txStartC = 1'b0;
   logic [19:0] dataC = '0;
   logic        txReadyC, txByteStartC;
   logic [7:0]  byteForTxC;
   logic        rxNewC = 1'b0;
   logic [7:0]  byteC = '0;
   logic [19:0] dataToMemC;
   logic        rxDoneC, rxTimeoutC;

   logic       uReady;
   logic [3:0] busy;
   logic [7:0] curByte;
   logic       lbPulse;
   logic [7:0] lbByte;

   assign rxNewA      = loop ? lbPulse : rxNewDrvA;
   assign byteFromRxA = loop ? lbByte : byteDrvA;

   uart_word_codec #(.WORD_SIZE(24), .UART_WIDTH(8), .MSB_FIRST(1),
                     .TIMEOUT_CYCLES(1000)) dutA (
      .clk(clk), .rstN(rstN), .txStart(txStartA), .dataFromMem(dataA),
      .txReady(txReadyA), .txByteReady(uReady), .txByteStart(txByteStartA),
      .byteForTx(byteForTxA), .rx_new_byte_indicate(rxNewA),
      .byteFromRx(byteFromRxA), .dataToMem(dataToMemA), .rxDone(rxDoneA),
      .rxTimeout(rxTimeoutA));

   uart_word_codec #(.WORD_SIZE(24), .UART_WIDTH(8), .MSB_FIRST(0),
                     .TIMEOUT_CYCLES(1000)) dutB (
      .clk(clk), .rstN(rstN), .txStart(txStartB), .dataFromMem(dataB),
      .txReady(txReadyB), .txByteReady(uReady), .txByteStart(txByteStartB),
      .byteForTx(byteForTxB), .rx_new_byte_indicate(rxNewB),
      .byteFromRx(byteB), .dataToMem(dataToMemB), .rxDone(rxDoneB),
      .rxTimeout(rxTimeoutB));

   uart_word_codec #(.WORD_SIZE(20), .UART_WIDTH(8), .MSB_FIRST(1),
                     .TIMEOUT_CYCLES(1000)) dutC (
      .clk(clk), .rstN(rstN), .txStart(txStartC), .dataFromMem(dataC),
      .txReady(txReadyC), .txByteReady(uReady), .txByteStart(txByteStartC),
      .byteForTx(byteForTxC), .rx_new_byte_indicate(rxNewC),
      .byteFromRx(byteC), .dataToMem(dataToMemC), .rxDone(rxDoneC),
      .rxTimeout(rxTimeoutC));

   // UART TX model: drops ready for BUSY cycles per byte, then
   // optionally delivers the byte back as an RX pulse.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         uReady  <= 1'b1;
         busy    <= '0;
         curByte <= '0;
         lbPulse <= 1'b0;
         lbByte  <= '0;
      end else begin
         lbPulse <= 1'b0;
         if (txByteStartA | txByteStartB | txByteStartC) begin
            uReady  <= 1'b0;
            busy    <= 4'(BUSY);
            curByte <= txByteStartA ? byteForTxA :
                       txByteStartB ? byteForTxB : byteForTxC;
         end else if (busy != 0) begin
            busy <= busy - 1'b1;
            if (busy == 1) begin
               uReady  <= 1'b1;
               lbPulse <= loop;
               lbByte  <= curByte;
            end
         end
      end
   end

   logic [7:0] logA [256];
   logic [7:0] logB [256];
   logic [7:0] logC [256];
   int nA = 0, nB = 0, nC = 0;
   int doneA = 0, toA = 0, doneC = 0;

   always @(posedge clk) begin
      if (txByteStartA) begin logA[nA[7:0]] <= byteForTxA; nA <= nA + 1; end
      if (txByteStartB) begin logB[nB[7:0]] <= byteForTxB; nB <= nB + 1; end
      if (txByteStartC) begin logC[nC[7:0]] <= byteForTxC; nC <= nC + 1; end
      doneA <= doneA + int'(rxDoneA);
      toA   <= toA + int'(rxTimeoutA);
      doneC <= doneC + int'(rxDoneC);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic startTx(input int which, input logic [23:0] w);
      @(negedge clk);
      case (which)
         0: begin txStartA = 1'b1; dataA = w; end
         1: begin txStartB = 1'b1; dataB = w; end
         default: begin txStartC = 1'b1; dataC = w[19:0]; end
      endcase
      @(negedge clk);
      txStartA = 1'b0;
      txStartB = 1'b0;
      txStartC = 1'b0;
   endtask

   task automatic waitIdle(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if ((which == 0 && txReadyA) || (which == 1 && txReadyB)
             || (which == 2 && txReadyC)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic rxByte(input int which, input logic [7:0] b);
      @(negedge clk);
      if (which == 0) begin rxNewDrvA = 1'b1; byteDrvA = b; end
      else begin rxNewC = 1'b1; byteC = b; end
      @(negedge clk);
      rxNewDrvA = 1'b0;
      rxNewC    = 1'b0;
   endtask

   initial begin
      bit ok;
      int s, d0, t0, waited;
      logic [23:0] w;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst.txReady", 32'(txReadyA), 1);
      chk("rst.txByteStart", 32'(txByteStartA), 0);
      chk("rst.byteForTx", 32'(byteForTxA), 0);
      chk("rst.dataToMem", 32'(dataToMemA), 0);
      chk("rst.rxDone", 32'(rxDoneA), 0);
      chk("rst.rxTimeout", 32'(rxTimeoutA), 0);
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      // MSB first, 24-bit
      s = nA;
      startTx(0, 24'hA1B2C3);
      chk("A.lat.start", 32'(txByteStartA), 1);
      chk("A.lat.byte", 32'(byteForTxA), 32'hA1);
      chk("A.lat.ready", 32'(txReadyA), 0);
      waitIdle(0, ok);
      chk("A.idle", 32'(ok), 1);
      chk("A.nbytes", 32'(nA - s), 3);
      chk("A.b0", 32'(logA[s[7:0]]), 32'hA1);
      chk("A.b1", 32'(logA[8'(s + 1)]), 32'hB2);
      chk("A.b2", 32'(logA[8'(s + 2)]), 32'hC3);

      // LSB first
      s = nB;
      startTx(1, 24'hA1B2C3);
      waitIdle(1, ok);
      chk("B.idle", 32'(ok), 1);
      chk("B.nbytes", 32'(nB - s), 3);
      chk("B.b0", 32'(logB[s[7:0]]), 32'hC3);
      chk("B.b1", 32'(logB[8'(s + 1)]), 32'hB2);
      chk("B.b2", 32'(logB[8'(s + 2)]), 32'hA1);

      // 20-bit word, padded MS byte
      s = nC;
      startTx(2, 24'h0ABCDE);
      waitIdle(2, ok);
      chk("C.idle", 32'(ok), 1);
      chk("C.nbytes", 32'(nC - s), 3);
      chk("C.b0", 32'(logC[s[7:0]]), 32'h0A);
      chk("C.b1", 32'(logC[8'(s + 1)]), 32'hBC);
      chk("C.b2", 32'(logC[8'(s + 2)]), 32'hDE);

      // reset mid-word, then resend and ignore txStart while busy
      startTx(0, 24'hA0A0A0);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      chk("midrst.txByteStart", 32'(txByteStartA), 0);
      chk("midrst.txReady", 32'(txReadyA), 1);
      chk("midrst.byteForTx", 32'(byteForTxA), 0);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      s = nA;
      startTx(0, 24'h010203);
      txStartA = 1'b1;
      dataA = 24'hFFFFFF;
      @(negedge clk);
      txStartA = 1'b0;
      waitIdle(0, ok);
      chk("resend.idle", 32'(ok), 1);
      repeat (40) @(negedge clk);
      chk("resend.nbytes", 32'(nA - s), 3);
      chk("resend.b0", 32'(logA[s[7:0]]), 32'h01);
      chk("resend.b1", 32'(logA[8'(s + 1)]), 32'h02);
      chk("resend.b2", 32'(logA[8'(s + 2)]), 32'h03);

      // RX assembly
      d0 = doneA;
      rxByte(0, 8'h12);
      rxByte(0, 8'h34);
      chk("rxA.partial", 32'(dataToMemA), 0);
      rxByte(0, 8'h56);
      chk("rxA.done", 32'(rxDoneA), 1);
      chk("rxA.data", 32'(dataToMemA), 32'h123456);
      @(negedge clk);
      chk("rxA.donePulse", 32'(rxDoneA), 0);
      chk("rxA.doneCnt", 32'(doneA - d0), 1);

      d0 = doneC;
      rxByte(2, 8'hFA);
      rxByte(2, 8'hBC);
      rxByte(2, 8'hDE);
      chk("rxC.data", 32'(dataToMemC), 32'hABCDE);
      @(negedge clk);
      chk("rxC.doneCnt", 32'(doneC - d0), 1);

      // timeout drops a partial word
      d0 = doneA;
      t0 = toA;
      rxByte(0, 8'h11);
      rxByte(0, 8'h22);
      waited = 0;
      while (toA == t0 && waited < 1200) begin
         @(negedge clk);
         waited++;
      end
      chk("to.count", 32'(toA - t0), 1);
      chk("to.latency", 32'(waited >= 990 && waited <= 1010), 1);
      chk("to.dataHeld", 32'(dataToMemA), 32'h123456);
      chk("to.noDone", 32'(doneA - d0), 0);
      rxByte(0, 8'h77);
      rxByte(0, 8'h88);
      rxByte(0, 8'h99);
      chk("to.after", 32'(dataToMemA), 32'h778899);

      // loopback
      @(negedge clk);
      loop = 1'b1;
      d0 = doneA;
      t0 = toA;
      for (int k = 0; k < 5; k++) begin
         w = 24'($urandom & 32'hFFFFFF);
         startTx(0, w);
         waitIdle(0, ok);
         chk("lb.idle", 32'(ok), 1);
         repeat (3) @(negedge clk);
         chk("lb.word", 32'(dataToMemA), 32'(w));
      end
      chk("lb.doneCnt", 32'(doneA - d0), 5);
      chk("lb.toCnt", 32'(toA - t0), 0);
      loop = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
